// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: drives one external full_adder cell over two
// WIDTH-bit operands, LSB first, with a start/busy/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_ci,
  input  logic             fa_s,
  input  logic             fa_co
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_shifted;

  // The adder bit of this cycle enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
  assign sum_shifted = {fa_s, sum_sh_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    sum_sh_d = sum_sh_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    busy_d   = busy_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d   = a;
          b_sh_d   = b;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          busy_d   = 1'b1;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        sum_sh_d = sum_shifted;
        carry_d  = fa_co;
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Final bit: publish the result and leave RUN without letting cnt wrap.
          cnt_d   = '0;
          sum_d   = sum_shifted;
          cout_d  = fa_co;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      sum_sh_q <= sum_sh_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // The adder is only fed while bits are being stepped; it sees zeros otherwise.
  assign fa_a  = (state_q == S_RUN) & a_sh_q[0];
  assign fa_b  = (state_q == S_RUN) & b_sh_q[0];
  assign fa_ci = (state_q == S_RUN) & carry_q;

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: WIDTH=8 vector table plus corner
// sequences, and an exhaustive back-to-back sweep on a WIDTH=4 instance.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance with its full adder
  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, cout8, fa_a8, fa_b8, fa_ci8, fa_s8, fa_co8;
  logic [7:0] sum8;

  assign fa_s8  = fa_a8 ^ fa_b8 ^ fa_ci8;
  assign fa_co8 = (fa_a8 & fa_b8) | (fa_a8 & fa_ci8) | (fa_b8 & fa_ci8);

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_ci(fa_ci8), .fa_s(fa_s8), .fa_co(fa_co8)
  );

  // WIDTH=4 instance with its full adder
  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, cout4, fa_a4, fa_b4, fa_ci4, fa_s4, fa_co4;
  logic [3:0] sum4;

  assign fa_s4  = fa_a4 ^ fa_b4 ^ fa_ci4;
  assign fa_co4 = (fa_a4 & fa_b4) | (fa_a4 & fa_ci4) | (fa_b4 & fa_ci4);

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4),
    .fa_a(fa_a4), .fa_b(fa_b4), .fa_ci(fa_ci4), .fa_s(fa_s4), .fa_co(fa_co4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] s;
    logic       co;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One start pulse; checks latency, result, single-cycle done and idle adder inputs.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic eco, input string nm);
    int lat;
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    step();
    start8 = 1'b0;
    lat = 1;
    chk({nm, " busy"}, 32'(busy8), 32'd1);
    while (!done8 && lat < 20) begin
      step();
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'd9);
    chk({nm, " sum"}, 32'(sum8), 32'(es));
    chk({nm, " cout"}, 32'(cout8), 32'(eco));
    $display("op %s: a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", nm, ta, tb, tc, sum8, cout8);
    step();
    chk({nm, " done width"}, 32'(done8), 32'd0);
    chk({nm, " busy low"}, 32'(busy8), 32'd0);
    chk({nm, " idle fa"}, 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
    chk({nm, " sum hold"}, 32'(sum8), 32'(es));
  endtask

  initial begin
    int nd;
    logic [7:0] seen_sum;
    int prev_cyc;
    int waited;
    int expv;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[7] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};

    #2;
    chk("reset busy", 32'(busy8), 32'd0);
    chk("reset done", 32'(done8), 32'd0);
    chk("reset sum", 32'(sum8), 32'd0);
    chk("reset cout", 32'(cout8), 32'd0);
    chk("reset fa", 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++)
      run8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co, $sformatf("vec%0d", i));

    // Carry ripple: fa_ci must be 1 for bits 1..7 of 0xFF+0x01
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("ripple bit0 fa", 32'({fa_a8, fa_b8, fa_ci8}), 32'b110);
    for (int i = 1; i < 8; i++) begin
      step();
      chk($sformatf("ripple bit%0d fa_ci", i), 32'(fa_ci8), 32'd1);
    end
    step();
    chk("ripple done", 32'(done8), 32'd1);
    chk("ripple sum", 32'(sum8), 32'h00);
    chk("ripple cout", 32'(cout8), 32'd1);
    $display("op ripple: sum=%02h cout=%0d", sum8, cout8);
    step();

    // Start while busy is ignored
    a8 = 8'h3C; b8 = 8'h42; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    a8 = 8'h11; b8 = 8'h22; start8 = 1'b1;
    step();
    start8 = 1'b0;
    nd = 0;
    seen_sum = 8'hXX;
    for (int i = 0; i < 14; i++) begin
      if (done8) begin
        nd++;
        seen_sum = sum8;
      end
      step();
    end
    chk("busy-start done count", 32'(nd), 32'd1);
    chk("busy-start sum", 32'(seen_sum), 32'h7E);
    chk("busy-start idle", 32'(busy8), 32'd0);
    $display("op busy-start: done pulses=%0d sum=%02h", nd, seen_sum);

    // Asynchronous reset during bit 4
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(busy8), 32'd0);
    chk("midrst done", 32'(done8), 32'd0);
    chk("midrst sum", 32'(sum8), 32'd0);
    chk("midrst cout", 32'(cout8), 32'd0);
    chk("midrst fa", 32'({fa_a8, fa_b8, fa_ci8}), 32'd0);
    step();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) nd++;
      step();
    end
    chk("midrst no resume", 32'(nd), 32'd0);
    $display("op midrst: aborted, activity cycles after reset=%0d", nd);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post-rst");

    // Exhaustive WIDTH=4 sweep with start held
    prev_cyc = 0;
    start4 = 1'b1;
    for (int k = 0; k < 512; k++) begin
      a4 = k[3:0]; b4 = k[7:4]; cin4 = k[8];
      waited = 0;
      while (!done4 && waited < 20) begin
        step();
        waited++;
      end
      chk($sformatf("w4 op%0d done", k), 32'(done4), 32'd1);
      expv = k[3:0] + k[7:4] + int'(k[8]);
      chk($sformatf("w4 op%0d result", k), 32'({cout4, sum4}), 32'(expv));
      if (k > 0)
        chk($sformatf("w4 op%0d spacing", k), 32'(cyc - prev_cyc), 32'd6);
      prev_cyc = cyc;
      $display("w4 op%0d: a=%0h b=%0h cin=%0d -> cout=%0d sum=%0h", k, k[3:0], k[7:4], k[8], cout4, sum4);
      step();
      chk($sformatf("w4 op%0d done width", k), 32'(done4), 32'd0);
    end
    start4 = 1'b0;
    repeat (8) step();
    chk("w4 final idle", 32'(busy4), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial addition controller that sequences a single external `full_adder` cell over two WIDTH-bit operands, one bit per clock, LSB first. It owns the operand shift registers, the carry flip-flop, the bit counter and a start/busy/done handshake. It sits between a requesting unit and one `full_adder` instance, so an N-bit add costs one adder cell and WIDTH cycles.

## Interface
Parameters:
- WIDTH, 8, operand/sum width in bits; legal range WIDTH >= 2

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  WIDTH  operand A, captured on the accepting edge
- b  in  WIDTH  operand B, captured on the accepting edge
- cin  in  1  carry-in, captured on the accepting edge
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse, high in DONE
- sum  out  WIDTH  result; held from DONE until the next accepted start
- cout  out  1  final carry-out; held like sum
- fa_a  out  1  to full_adder `a`
- fa_b  out  1  to full_adder `b`
- fa_ci  out  1  to full_adder `ci`
- fa_s  in  1  from full_adder `s`
- fa_co  in  1  from full_adder `co`

## Operation
- One clock domain. `rst` is asynchronous and active-high.
- FSM states:
  - IDLE: wait for `start`.
  - RUN: WIDTH bit steps.
  - DONE: one cycle, then IDLE.
- IDLE, `start`=1 at an edge:
  - a_sh <= a, b_sh <= b, carry <= cin, cnt <= 0, sum_sh <= 0.
  - State goes to RUN.
- RUN drives the adder combinationally: fa_a = a_sh[0], fa_b = b_sh[0], fa_ci = carry.
- Each RUN edge:
  - sum_sh <= {fa_s, sum_sh[WIDTH-1:1]}.
  - carry <= fa_co.
  - a_sh and b_sh shift right by one, zero-filled.
  - cnt <= cnt + 1.
- RUN edge with cnt == WIDTH-1: the last shift happens, cout <= fa_co, and state goes to DONE.
- DONE: done = 1, sum = sum_sh, valid. The next edge goes to IDLE unconditionally.
- In IDLE and DONE, fa_a = fa_b = fa_ci = 0.
- `sum` and `cout` are registered and do not change in IDLE. They update only as the result of a new operation.
- Arithmetic: {cout, sum} = a + b + cin, with a (WIDTH+1)-bit exact result and no overflow flag.
- cnt width is $clog2(WIDTH). cnt never wraps inside RUN; it is reset to 0 on accept.
- `start` while busy (RUN or DONE) is ignored. It is not queued, and operands present at that edge are not captured.
- `start` held high continuously starts a new operation on the first IDLE edge after each DONE.
- Changes on a/b/cin after the accepting edge have no effect on the running operation.
- Reset, including mid-RUN: the operation is aborted and no done pulse is issued.
  - state = IDLE, busy = 0, done = 0, sum = 0, cout = 0, carry = 0, cnt = 0.
  - Shift registers are cleared.
  - fa_* outputs = 0.

## Timing
- E0 is the accepting edge. busy rises after E0.
- Bit i (0..WIDTH-1) is presented on fa_* during the cycle E(i)..E(i+1). It is captured at E(i+1).
- After E(WIDTH): state DONE, done = 1, sum/cout valid.
- After E(WIDTH+1): state IDLE, done = 0, busy = 0.
- Latency from accept to done is WIDTH+1 edges. Throughput is one add per WIDTH+2 cycles, with `start` held.
- The full_adder path is combinational: fa_s and fa_co must settle within one cycle of fa_* changing.
- Reset is asynchronous. Outputs take their reset values without a clock edge. Deassertion is synchronous to clk at the system level.

## Test plan
Use WIDTH=8 with a real `full_adder` attached unless stated otherwise.
- **Zero operands:** a=0x00, b=0x00, cin=0 -> done pulses after the 9th edge, sum=0x00, cout=0, busy low after the 10th edge.
- **Full carry ripple:** a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Also check fa_ci is 1 during bits 1..7.
- **Carry-in used:** a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Separately, a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
- **Start while busy:** pulse `start` with a=0x11, b=0x22 at edge 3 of an active 0x3C+0x42 add -> result stays 0x7E. Exactly one done pulse. The machine returns to IDLE with no second run.
- **Reset mid-RUN:** assert rst during bit 4 of 0xFF+0x01 -> immediately busy=0, done=0, sum=0x00, cout=0, fa_*=0. No done follows. A subsequent 0x01+0x01 gives sum=0x02.
- **Exhaustive at WIDTH=4:** run all 512 (a, b, cin) combinations back-to-back with `start` held -> every {cout, sum} equals a+b+cin. Each done pulse is exactly 1 cycle, and done pulses are spaced 6 cycles apart.
